// File: rtl/msx_sdram_arbiter.sv
// rtl/msx_sdram_arbiter.sv - CPU/flash arbiter and sequencer for the shared SDRAM port
//
// Serializes CPU slot accesses and flash-emulation writes onto one SDRAM
// controller request port. CPU has priority; flash is granted after at most
// STARVE_LIMIT consecutive CPU grants while it waits.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   cpu_ce/addr/wdata/rnw       CPU access (captured on rising edge of cpu_ce)
//   cpu_rdata, cpu_wait         latched read data, access-in-progress wait
//   flash_req/addr/wdata        one-cycle flash write request
//   flash_ready, flash_done     request acceptance, completion pulse
//   sdram_req/addr/wdata/we     request to SDRAM controller (held until ack)
//   sdram_ack, sdram_rdata      one-cycle acknowledge with read data

module msx_sdram_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_ce,
    input  logic [26:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_rnw,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_wait,
    input  logic        flash_req,
    input  logic [26:0] flash_addr,
    input  logic [7:0]  flash_wdata,
    output logic        flash_ready,
    output logic        flash_done,
    output logic        sdram_req,
    output logic [26:0] sdram_addr,
    output logic [7:0]  sdram_wdata,
    output logic        sdram_we,
    input  logic        sdram_ack,
    input  logic [7:0]  sdram_rdata
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CPU_BUSY   = 2'd1,
        FLASH_BUSY = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state;
    state_t      state_nxt;

    logic        cpu_ce_q;
    logic        cpu_edge;
    logic        cpu_pend;
    logic [26:0] cpu_addr_c;
    logic [7:0]  cpu_wdata_c;
    logic        cpu_rnw_c;

    logic        flash_pend;
    logic [26:0] flash_addr_c;
    logic [7:0]  flash_wdata_c;

    logic [3:0]  starve_cnt;
    logic        grant_cpu;
    logic        grant_flash;

    assign cpu_edge = cpu_ce & ~cpu_ce_q;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and grant decision
    always_comb begin
        state_nxt   = state;
        grant_cpu   = 1'b0;
        grant_flash = 1'b0;
        case (state)
            IDLE: begin
                if (flash_pend && (!cpu_pend || starve_cnt == LIMIT)) begin
                    grant_flash = 1'b1;
                    state_nxt   = FLASH_BUSY;
                end else if (cpu_pend) begin
                    grant_cpu = 1'b1;
                    state_nxt = CPU_BUSY;
                end
            end
            CPU_BUSY, FLASH_BUSY: begin
                if (sdram_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs; cpu_wait includes the raw edge so the CPU is held in the edge cycle
    always_comb begin
        sdram_req   = (state != IDLE);
        flash_ready = ~flash_pend & (state != FLASH_BUSY);
        cpu_wait    = cpu_pend | (state == CPU_BUSY) | cpu_edge;
    end

    // Request capture. A new edge takes precedence over the grant clearing
    // the pending bit: the grant has already consumed the previous capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_ce_q      <= 1'b0;
            cpu_pend      <= 1'b0;
            cpu_addr_c    <= '0;
            cpu_wdata_c   <= '0;
            cpu_rnw_c     <= 1'b1;
            flash_pend    <= 1'b0;
            flash_addr_c  <= '0;
            flash_wdata_c <= '0;
        end else begin
            cpu_ce_q <= cpu_ce;
            if (cpu_edge) begin
                cpu_pend    <= 1'b1;
                cpu_addr_c  <= cpu_addr;
                cpu_wdata_c <= cpu_wdata;
                cpu_rnw_c   <= cpu_rnw;
            end else if (grant_cpu) begin
                cpu_pend <= 1'b0;
            end
            if (flash_req && flash_ready) begin
                flash_pend    <= 1'b1;
                flash_addr_c  <= flash_addr;
                flash_wdata_c <= flash_wdata;
            end else if (grant_flash) begin
                flash_pend <= 1'b0;
            end
        end
    end

    // SDRAM bus registers are loaded at grant so they stay stable for the
    // whole request even if a new capture overwrites the pending slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sdram_addr  <= '0;
            sdram_wdata <= '0;
            sdram_we    <= 1'b0;
            starve_cnt  <= '0;
        end else if (grant_flash) begin
            sdram_addr  <= flash_addr_c;
            sdram_wdata <= flash_wdata_c;
            sdram_we    <= 1'b1;
            starve_cnt  <= '0;
        end else if (grant_cpu) begin
            sdram_addr  <= cpu_addr_c;
            sdram_wdata <= cpu_wdata_c;
            sdram_we    <= ~cpu_rnw_c;
            if (!flash_pend) begin
                starve_cnt <= '0;
            end else if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

    // Completion: read data latch and flash completion pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_rdata  <= 8'hFF;
            flash_done <= 1'b0;
        end else begin
            if (state == CPU_BUSY && sdram_ack && !sdram_we) begin
                cpu_rdata <= sdram_rdata;
            end
            flash_done <= (state == FLASH_BUSY) && sdram_ack;
        end
    end

endmodule

// File: tb/tb_msx_sdram_arbiter.sv
// tb/tb_msx_sdram_arbiter.sv - scoreboard bench for msx_sdram_arbiter

module tb_msx_sdram_arbiter;

    localparam int LIMIT = 4;

    typedef struct packed {
        logic [26:0] addr;
        logic [7:0]  wdata;
        logic        we;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_ce;
    logic [26:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_rnw;
    logic [7:0]  cpu_rdata;
    logic        cpu_wait;
    logic        flash_req;
    logic [26:0] flash_addr;
    logic [7:0]  flash_wdata;
    logic        flash_ready;
    logic        flash_done;
    logic        sdram_req;
    logic [26:0] sdram_addr;
    logic [7:0]  sdram_wdata;
    logic        sdram_we;
    logic        sdram_ack;
    logic [7:0]  sdram_rdata;

    always #5 clk = ~clk;

    msx_sdram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .cpu_ce(cpu_ce), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rnw(cpu_rnw),
        .cpu_rdata(cpu_rdata), .cpu_wait(cpu_wait),
        .flash_req(flash_req), .flash_addr(flash_addr), .flash_wdata(flash_wdata),
        .flash_ready(flash_ready), .flash_done(flash_done),
        .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_wdata(sdram_wdata),
        .sdram_we(sdram_we), .sdram_ack(sdram_ack), .sdram_rdata(sdram_rdata)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending slots, owner of the bus, and how many CPU
    // grants in a row have passed over a waiting flash write.
    txn_t        exp_q[$];
    int          m_state;      // 0 free, 1 CPU owns bus, 2 flash owns bus
    bit          m_cpu_pend, m_fl_pend, m_ce_q, m_done, m_flr, m_dn;
    txn_t        m_cpu, m_fl, m_cur;
    int          m_run;
    logic [7:0]  m_rdata;

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_state = 0; m_cpu_pend = 0; m_fl_pend = 0; m_ce_q = 0;
                m_done = 0; m_run = 0; m_rdata = 8'hFF;
                exp_q.delete();
            end else begin
                m_flr = !m_fl_pend && m_state != 2;
                m_dn  = 0;
                if (m_state == 0) begin
                    if (m_fl_pend && (!m_cpu_pend || m_run == LIMIT)) begin
                        m_state = 2; m_cur = m_fl; m_fl_pend = 0; m_run = 0;
                        exp_q.push_back(m_cur);
                    end else if (m_cpu_pend) begin
                        m_state = 1; m_cur = m_cpu; m_cpu_pend = 0;
                        m_run = m_fl_pend ? ((m_run + 1 > LIMIT) ? LIMIT : m_run + 1) : 0;
                        exp_q.push_back(m_cur);
                    end
                end else if (sdram_ack) begin
                    if (m_state == 1 && !m_cur.we) m_rdata = sdram_rdata;
                    if (m_state == 2) m_dn = 1;
                    m_state = 0;
                end
                if (cpu_ce && !m_ce_q) begin
                    m_cpu_pend = 1;
                    m_cpu = '{addr: cpu_addr, wdata: cpu_wdata, we: !cpu_rnw};
                end
                if (flash_req && m_flr) begin
                    m_fl_pend = 1;
                    m_fl = '{addr: flash_addr, wdata: flash_wdata, we: 1'b1};
                end
                m_ce_q = cpu_ce;
                m_done = m_dn;
            end
        end
    end

    // Monitor
    bit   prev_req = 0;
    bit   have_exp = 0;
    txn_t cur_exp;
    int   grant_we[$];
    int   done_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            chk("sdram_req", sdram_req, m_state != 0);
            chk("cpu_wait", cpu_wait, m_cpu_pend || m_state == 1 || (cpu_ce && !m_ce_q));
            chk("flash_ready", flash_ready, !m_fl_pend && m_state != 2);
            chk("flash_done", flash_done, m_done);
            chk("cpu_rdata", cpu_rdata, m_rdata);
            if (flash_done) done_cnt++;
            if (reset) begin
                prev_req = 0;
                have_exp = 0;
            end else if (sdram_req) begin
                if (!prev_req) begin
                    grant_we.push_back(int'(sdram_we));
                    chk("grant_expected", exp_q.size() > 0, 1);
                    have_exp = exp_q.size() > 0;
                    if (have_exp) cur_exp = exp_q.pop_front();
                end
                if (have_exp) begin
                    chk("sdram_addr", sdram_addr, cur_exp.addr);
                    chk("sdram_wdata", sdram_wdata, cur_exp.wdata);
                    chk("sdram_we", sdram_we, cur_exp.we);
                end
            end
            prev_req = sdram_req;
        end
    end

    // SDRAM controller responder
    int         fixed_delay = -1;
    bit         fixed_rd_en = 0;
    logic [7:0] fixed_rd    = 8'h00;
    bit         hold_ack    = 0;
    bit         spurious_en = 0;
    int         wait_cnt    = 0;

    function automatic int next_delay();
        return (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
    endfunction

    initial begin
        sdram_ack   = 0;
        sdram_rdata = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                sdram_ack = 0;
                wait_cnt  = next_delay();
            end else if (sdram_ack) begin
                sdram_ack = 0;
            end else if (sdram_req) begin
                if (!hold_ack) begin
                    if (wait_cnt <= 0) begin
                        sdram_ack   = 1;
                        sdram_rdata = fixed_rd_en ? fixed_rd : 8'($urandom);
                        wait_cnt    = next_delay();
                    end else begin
                        wait_cnt--;
                    end
                end
            end else begin
                wait_cnt = next_delay();
                if (spurious_en && $urandom_range(0, 7) == 0) begin
                    sdram_ack   = 1;
                    sdram_rdata = 8'($urandom);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (!(sdram_req == 0 && !cpu_wait && flash_ready) && k < 300) begin
            tick();
            k++;
        end
        chk("idle_reached", k < 300, 1);
        tick();
    endtask

    int g0, d0, k, ce_left;

    initial begin
        reset = 1; cpu_ce = 0; cpu_addr = '0; cpu_wdata = '0; cpu_rnw = 1;
        flash_req = 0; flash_addr = '0; flash_wdata = '0;
        repeat (3) @(posedge clk);
        #1 reset = 0;

        @(negedge clk);
        chk("rst_sdram_addr", sdram_addr, 0);
        chk("rst_sdram_wdata", sdram_wdata, 0);
        chk("rst_sdram_we", sdram_we, 0);
        chk("rst_cpu_rdata", cpu_rdata, 8'hFF);
        chk("rst_cpu_wait", cpu_wait, 0);
        chk("rst_flash_ready", flash_ready, 1);

        // CPU read on idle bus, ack two cycles after request
        fixed_delay = 2; fixed_rd_en = 1; fixed_rd = 8'h5A;
        tick(); tick();
        cpu_ce = 1; cpu_addr = 27'h0001234; cpu_rnw = 1;
        @(negedge clk); chk("rd_req_n0", sdram_req, 0); chk("rd_wait_n0", cpu_wait, 1);
        @(negedge clk); chk("rd_req_n1", sdram_req, 0);
        @(negedge clk); chk("rd_req_n2", sdram_req, 1); chk("rd_addr_n2", sdram_addr, 27'h0001234);
        @(negedge clk); chk("rd_req_n3", sdram_req, 1);
        @(negedge clk); chk("rd_req_n4", sdram_req, 1);
        @(negedge clk); chk("rd_req_n5", sdram_req, 0);
        chk("rd_rdata_n5", cpu_rdata, 8'h5A); chk("rd_wait_n5", cpu_wait, 0);
        tick(); cpu_ce = 0;
        fixed_delay = -1; fixed_rd_en = 0;

        // Flash write
        wait_idle();
        flash_req = 1; flash_addr = 27'h0100000; flash_wdata = 8'hC3;
        d0 = done_cnt;
        tick(); flash_req = 0;
        @(negedge clk); chk("fl_ready_after_req", flash_ready, 0);
        repeat (12) tick();
        chk("fl_done_pulses", done_cnt - d0, 1);

        // CPU write dropped before ack
        wait_idle();
        cpu_ce = 1; cpu_rnw = 0; cpu_addr = 27'h0000777; cpu_wdata = 8'h11;
        tick(); cpu_ce = 0;
        wait_idle();

        // Simultaneous request, then CPU keeps flash waiting
        wait_idle();
        g0 = grant_we.size();
        cpu_rnw = 1; cpu_ce = 1; cpu_addr = 27'($urandom);
        flash_req = 1; flash_addr = 27'h0200000; flash_wdata = 8'h3C;
        tick(); flash_req = 0;
        for (int i = 0; i < 60; i++) begin
            cpu_ce = ~cpu_ce;
            if (cpu_ce) cpu_addr = 27'($urandom);
            tick();
        end
        cpu_ce = 0;
        wait_idle();
        chk("starve_log_len", grant_we.size() - g0 >= 6, 1);
        if (grant_we.size() - g0 >= 6) begin
            for (int i = 0; i < 6; i++) begin
                chk($sformatf("starve_grant_%0d", i), grant_we[g0 + i], (i == 4) ? 1 : 0);
            end
        end

        // Reset while flash owns the bus
        wait_idle();
        hold_ack = 1;
        flash_req = 1; flash_addr = 27'h0300000; flash_wdata = 8'h99;
        tick(); flash_req = 0;
        k = 0;
        while (!(sdram_req && sdram_we) && k < 20) begin tick(); k++; end
        chk("fl_busy_reached", k < 20, 1);
        d0 = done_cnt;
        @(posedge clk);
        #3 reset = 1;
        #1;
        chk("rst_async_req", sdram_req, 0);
        chk("rst_async_ready", flash_ready, 1);
        repeat (2) @(posedge clk);
        #1 reset = 0; hold_ack = 0;
        repeat (5) tick();
        chk("rst_no_done", done_cnt - d0, 0);
        chk("rst_ready_after", flash_ready, 1);

        // Randomized traffic with spurious acks while idle
        spurious_en = 1;
        ce_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (ce_left == 0) begin
                if (cpu_ce) begin
                    cpu_ce = 0;
                    ce_left = $urandom_range(1, 4);
                end else begin
                    cpu_ce = 1;
                    cpu_addr = 27'($urandom);
                    cpu_wdata = 8'($urandom);
                    cpu_rnw = 1'($urandom);
                    ce_left = $urandom_range(1, 6);
                end
            end else begin
                ce_left--;
            end
            flash_req = 0;
            if ((flash_ready && $urandom_range(0, 3) == 0) || $urandom_range(0, 15) == 0) begin
                flash_req = 1;
                flash_addr = 27'($urandom);
                flash_wdata = 8'($urandom);
            end
            tick();
        end
        flash_req = 0; cpu_ce = 0; spurious_en = 0;
        wait_idle();
        chk("final_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
